rv_fetch: RTL and testbench
===========================

Name: rv_fetch

Overview:
- Instruction fetch stage of the uRV pipeline; the producer side of the fetch-to-decode interface.
- Issues sequential word reads to instruction memory and redirects on taken branches/jumps from execute.
- Presents f_ir_o/f_pc_o/f_valid_o to decode and honours the decode stall.
- At most one request outstanding; sustains 1 instruction/cycle when memory and decode never stall.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset; must be word aligned.

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_n_i  input  1  asynchronous active-low reset
- im_addr_o  output  32  fetch address (combinational from state and im_valid_i/x_bra_i)
- im_rd_o  output  1  read request for im_addr_o this cycle
- im_data_i  input  32  instruction data
- im_valid_i  input  1  im_data_i answers the request issued in the previous cycle; low = not served, must be reissued
- f_stall_i  input  1  decode stalled; fetch outputs must hold
- x_bra_i  input  1  redirect pulse from execute
- x_bra_target_i  input  32  redirect target, word aligned
- f_ir_o  output  32  instruction to decode
- f_pc_o  output  32  PC of f_ir_o
- f_valid_o  output  1  f_ir_o/f_pc_o valid

Behaviour:
- Reset: clk_i single clock; rst_n_i asynchronous assert, active low.
  - Reset values: f_valid_o=0, f_ir_o=0, f_pc_o=0, pending=0, flush=0, skid valid=0, state=BOOT, fetch_pc=RESET_VECTOR.
  - rst_n_i asserted mid-operation aborts everything immediately; the outstanding response is ignored.
- Memory protocol: a request is issued in cycle N when im_rd_o=1.
  - Its response is im_valid_i in N+1 only, and is ignored if no request was issued in N.
  - im_valid_i=0 in N+1 means unserved: fetch reissues the same address in N+1.
- State machine:
  - BOOT (1 cycle after reset release): im_rd_o=1, im_addr_o=RESET_VECTOR; -> RUN.
  - RUN: if pending and im_valid_i and output free: load output regs with {im_data_i, fetch_pc}, f_valid_o=1; issue fetch_pc+4. If pending and !im_valid_i: reissue fetch_pc.
  - STALL: entered when a response arrives while f_stall_i=1 and f_valid_o=1. Response handling depends on URV_FETCH_SKID_EN. im_rd_o=0 while in STALL. -> RUN the cycle after f_stall_i falls.
- Output free: f_stall_i=0 or f_valid_o=0.
- Hold: with f_stall_i=1 and f_valid_o=1, f_ir_o/f_pc_o/f_valid_o are held unchanged.
- Decode consumes f_ir_o on every cycle with f_stall_i=0; if no new response arrives that cycle, f_valid_o drops to 0.
- Redirect: x_bra_i=1 in cycle N (priority over f_stall_i and im_valid_i):
  - im_addr_o=x_bra_target_i and im_rd_o=1 in N.
  - f_valid_o=0 and skid cleared at edge N.
  - Any response arriving in N is discarded.
  - First redirected instruction has f_valid_o=1 at edge N+1 at the earliest.
  - x_bra_i in consecutive cycles: last target wins.
- Arithmetic: PC increment mod 2^32; fetch_pc=32'hFFFF_FFFC wraps to 0. im_addr_o[1:0] is always 0.
- No speculation beyond one request; fetch never issues a second address while pending without a response or retry.

Optional Feature:
- Macro URV_FETCH_SKID_EN.
- Defined: one-entry skid buffer {ir, pc, valid}.
  - A response arriving during stall is captured in the skid.
  - On stall release the skid moves to the outputs at the next edge, and fetch issues skid.pc+4 in the release cycle.
  - Result: no refetch penalty.
- Undefined: a response arriving during stall is dropped.
  - fetch_pc keeps that address and is reissued in the release cycle.
  - First post-stall instruction valid one cycle later than with the skid.
  - No skid storage is instantiated.

Test Plan:
- Reset, RESET_VECTOR=32'h100, memory always valid -> im_addr_o 100,104,108...; f_pc_o 100,104 on consecutive cycles, f_valid_o=1 from 2nd edge after BOOT.
- im_valid_i=0 for 3 cycles on address 104 -> im_addr_o=104 held 4 cycles; f_pc_o sequence 100,104,108 with no duplicate or skip.
- f_stall_i=1 for 4 cycles while f_pc_o=108 -> outputs held at 108.
  - With macro: f_pc_o=10C at first edge after release.
  - Without macro: 10C is refetched, f_valid_o=0 for one cycle, then 10C.
- x_bra_i with target 32'h200 while response for 110 arrives -> 110 never valid; f_valid_o=0 next edge; then f_pc_o=200,204.
- x_bra_i together with f_stall_i=1 -> redirect wins, f_valid_o=0, target fetched.
- Branch to 32'hFFFF_FFFC -> f_pc_o FFFF_FFFC then 0000_0000.
- rst_n_i asserted mid-stream -> f_valid_o=0 asynchronously; fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/rv_fetch.sv
// rv_fetch: uRV instruction fetch stage (producer side of fetch -> decode).
//
// Issues sequential word reads to instruction memory, keeps at most one
// request outstanding, retries unserved requests, and redirects on
// branch/jump pulses from execute. Decode sees f_ir_o/f_pc_o/f_valid_o and
// may stall; outputs hold while stalled.
//
// Build option: define URV_FETCH_SKID_EN to add a one-entry skid buffer
// that keeps a response arriving during a decode stall, removing the
// refetch bubble on stall release. Without it that response is dropped and
// the same address is fetched again when the stall releases.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_BOOT  | first cycle after reset, issue RESET_VECTOR
//   ST_RUN   | streaming: accept response, issue next / retry same address
//   ST_STALL | response arrived while decode held a valid instruction;
//            | no requests until decode releases the stall

module rv_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic [31:0] im_addr_o,
  output logic        im_rd_o,
  input  logic [31:0] im_data_i,
  input  logic        im_valid_i,
  input  logic        f_stall_i,
  input  logic        x_bra_i,
  input  logic [31:0] x_bra_target_i,
  output logic [31:0] f_ir_o,
  output logic [31:0] f_pc_o,
  output logic        f_valid_o
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        pending_q, pending_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] f_ir_q, f_ir_d;
  logic [31:0] f_pc_q, f_pc_d;
  logic        f_valid_q, f_valid_d;

  logic        rd;
  logic [31:0] addr;
  logic        out_free;
  logic [31:0] pc_inc;

`ifdef URV_FETCH_SKID_EN
  logic [31:0] skid_ir_q, skid_ir_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        skid_valid_q, skid_valid_d;
`endif

  // Decode can take a new instruction unless it is holding a valid one.
  assign out_free = ~f_stall_i | ~f_valid_q;
  // Wraps naturally from 32'hFFFF_FFFC to 0.
  assign pc_inc   = fetch_pc_q + 32'd4;

  // Request generation and next-state for all fetch registers.
  always_comb begin
    state_d    = state_q;
    pending_d  = 1'b0;
    fetch_pc_d = fetch_pc_q;
    f_ir_d     = f_ir_q;
    f_pc_d     = f_pc_q;
    f_valid_d  = f_valid_q;
    rd         = 1'b0;
    addr       = fetch_pc_q;
`ifdef URV_FETCH_SKID_EN
    skid_ir_d    = skid_ir_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;
`endif

    if (x_bra_i) begin
      // Redirect beats stall and any response arriving this cycle.
      rd         = 1'b1;
      addr       = x_bra_target_i;
      fetch_pc_d = x_bra_target_i;
      pending_d  = 1'b1;
      f_valid_d  = 1'b0;
      state_d    = ST_RUN;
`ifdef URV_FETCH_SKID_EN
      skid_valid_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_BOOT: begin
          rd        = 1'b1;
          addr      = fetch_pc_q;
          pending_d = 1'b1;
          state_d   = ST_RUN;
        end

        ST_RUN: begin
          // Decode consumes whatever it sees when not stalled.
          if (!f_stall_i) begin
            f_valid_d = 1'b0;
          end
          if (pending_q && im_valid_i) begin
            if (out_free) begin
              f_ir_d     = im_data_i;
              f_pc_d     = fetch_pc_q;
              f_valid_d  = 1'b1;
              rd         = 1'b1;
              addr       = pc_inc;
              fetch_pc_d = pc_inc;
              pending_d  = 1'b1;
            end else begin
              // Decode is holding a valid instruction: park and stop issuing.
              state_d = ST_STALL;
`ifdef URV_FETCH_SKID_EN
              skid_ir_d    = im_data_i;
              skid_pc_d    = fetch_pc_q;
              skid_valid_d = 1'b1;
`endif
            end
          end else begin
            // Unserved (or nothing outstanding): ask for the same word again.
            rd        = 1'b1;
            addr      = fetch_pc_q;
            pending_d = 1'b1;
          end
        end

        ST_STALL: begin
          if (!f_stall_i) begin
            state_d   = ST_RUN;
            rd        = 1'b1;
            pending_d = 1'b1;
`ifdef URV_FETCH_SKID_EN
            if (skid_valid_q) begin
              f_ir_d       = skid_ir_q;
              f_pc_d       = skid_pc_q;
              f_valid_d    = 1'b1;
              skid_valid_d = 1'b0;
              addr         = skid_pc_q + 32'd4;
              fetch_pc_d   = skid_pc_q + 32'd4;
            end else begin
              f_valid_d = 1'b0;
              addr      = fetch_pc_q;
            end
`else
            // Stalled response was dropped; fetch_pc still names it.
            f_valid_d = 1'b0;
            addr      = fetch_pc_q;
`endif
          end
        end

        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  // Fetch state, outputs and (optionally) skid entry; reset aborts any
  // outstanding request by clearing pending.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_BOOT;
      pending_q  <= 1'b0;
      fetch_pc_q <= RESET_VECTOR;
      f_ir_q     <= 32'd0;
      f_pc_q     <= 32'd0;
      f_valid_q  <= 1'b0;
`ifdef URV_FETCH_SKID_EN
      skid_ir_q    <= 32'd0;
      skid_pc_q    <= 32'd0;
      skid_valid_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      fetch_pc_q <= fetch_pc_d;
      f_ir_q     <= f_ir_d;
      f_pc_q     <= f_pc_d;
      f_valid_q  <= f_valid_d;
`ifdef URV_FETCH_SKID_EN
      skid_ir_q    <= skid_ir_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
`endif
    end
  end

  assign im_rd_o   = rd;
  assign im_addr_o = addr;
  assign f_ir_o    = f_ir_q;
  assign f_pc_o    = f_pc_q;
  assign f_valid_o = f_valid_q;

endmodule

// File: tb/tb_rv_fetch.sv
// Directed bench for rv_fetch with RESET_VECTOR = 32'h100.
// Instruction memory returns (requested address ^ 32'hA5A5_0000) one cycle
// after a request; im_valid_i is driven directly by the stimulus.
// Inputs change and outputs are checked just after the falling edge.

module tb_rv_fetch;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] im_addr_o;
  logic        im_rd_o;
  logic [31:0] im_data_i;
  logic        im_valid_i;
  logic        f_stall_i;
  logic        x_bra_i;
  logic [31:0] x_bra_target_i;
  logic [31:0] f_ir_o;
  logic [31:0] f_pc_o;
  logic        f_valid_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] addr_prev = 32'd0;

  rv_fetch #(.RESET_VECTOR(32'h0000_0100)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .im_addr_o      (im_addr_o),
    .im_rd_o        (im_rd_o),
    .im_data_i      (im_data_i),
    .im_valid_i     (im_valid_i),
    .f_stall_i      (f_stall_i),
    .x_bra_i        (x_bra_i),
    .x_bra_target_i (x_bra_target_i),
    .f_ir_o         (f_ir_o),
    .f_pc_o         (f_pc_o),
    .f_valid_o      (f_valid_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) addr_prev <= im_addr_o;
  assign im_data_i = addr_prev ^ 32'hA5A5_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk_i);
  endtask

  initial begin
    rst_n_i        = 1'b0;
    im_valid_i     = 1'b1;
    f_stall_i      = 1'b0;
    x_bra_i        = 1'b0;
    x_bra_target_i = 32'd0;

    // Reset state
    nxt(); #1;
    chk("rst_valid", {31'd0, f_valid_o}, 32'd0);
    chk("rst_pc",    f_pc_o, 32'd0);
    chk("rst_ir",    f_ir_o, 32'd0);

    // C0: BOOT
    nxt(); rst_n_i = 1'b1; #1;
    chk("boot_rd",   {31'd0, im_rd_o}, 32'd1);
    chk("boot_addr", im_addr_o, 32'h0000_0100);

    // C1
    nxt(); #1;
    chk("c1_valid", {31'd0, f_valid_o}, 32'd0);
    chk("c1_addr",  im_addr_o, 32'h0000_0104);

    // C2: first instruction out; memory refuses 104 for three cycles
    nxt(); im_valid_i = 1'b0; #1;
    chk("c2_valid", {31'd0, f_valid_o}, 32'd1);
    chk("c2_pc",    f_pc_o, 32'h0000_0100);
    chk("c2_ir",    f_ir_o, 32'hA5A5_0100);
    chk("c2_addr",  im_addr_o, 32'h0000_0104);

    nxt(); #1;
    chk("c3_valid", {31'd0, f_valid_o}, 32'd0);
    chk("c3_addr",  im_addr_o, 32'h0000_0104);

    nxt(); #1;
    chk("c4_addr",  im_addr_o, 32'h0000_0104);
    chk("c4_rd",    {31'd0, im_rd_o}, 32'd1);

    nxt(); im_valid_i = 1'b1; #1;
    chk("c5_addr",  im_addr_o, 32'h0000_0108);
    chk("c5_valid", {31'd0, f_valid_o}, 32'd0);

    nxt(); #1;
    chk("c6_pc",    f_pc_o, 32'h0000_0104);
    chk("c6_valid", {31'd0, f_valid_o}, 32'd1);
    chk("c6_addr",  im_addr_o, 32'h0000_010C);

    // C7..C10: decode stall while holding 108; response for 10C arrives in C7
    nxt(); f_stall_i = 1'b1; #1;
    chk("c7_pc",    f_pc_o, 32'h0000_0108);
    chk("c7_valid", {31'd0, f_valid_o}, 32'd1);
    chk("c7_rd",    {31'd0, im_rd_o}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk("stall_pc",    f_pc_o, 32'h0000_0108);
      chk("stall_valid", {31'd0, f_valid_o}, 32'd1);
      chk("stall_rd",    {31'd0, im_rd_o}, 32'd0);
    end

    // C11: release
    nxt(); f_stall_i = 1'b0; #1;
    chk("rel_pc",    f_pc_o, 32'h0000_0108);
    chk("rel_valid", {31'd0, f_valid_o}, 32'd1);
    chk("rel_rd",    {31'd0, im_rd_o}, 32'd1);
`ifdef URV_FETCH_SKID_EN
    chk("rel_addr",  im_addr_o, 32'h0000_0110);

    // C12: skid drained to outputs; response for 110 arrives with a redirect
    nxt();
    chk("skid_pc",    f_pc_o, 32'h0000_010C);
    chk("skid_valid", {31'd0, f_valid_o}, 32'd1);
    x_bra_i = 1'b1; x_bra_target_i = 32'h0000_0200; #1;
`else
    chk("rel_addr",  im_addr_o, 32'h0000_010C);

    // C12: bubble while 10C is refetched
    nxt(); #1;
    chk("bub_valid", {31'd0, f_valid_o}, 32'd0);
    chk("bub_addr",  im_addr_o, 32'h0000_0110);

    // C13: 10C out; response for 110 arrives with a redirect
    nxt();
    chk("refetch_pc",    f_pc_o, 32'h0000_010C);
    chk("refetch_valid", {31'd0, f_valid_o}, 32'd1);
    x_bra_i = 1'b1; x_bra_target_i = 32'h0000_0200; #1;
`endif
    chk("bra_addr", im_addr_o, 32'h0000_0200);
    chk("bra_rd",   {31'd0, im_rd_o}, 32'd1);

    nxt(); x_bra_i = 1'b0; #1;
    chk("bra_flush_valid", {31'd0, f_valid_o}, 32'd0);
    chk("bra_next_addr",   im_addr_o, 32'h0000_0204);

    nxt(); #1;
    chk("tgt_pc",    f_pc_o, 32'h0000_0200);
    chk("tgt_ir",    f_ir_o, 32'hA5A5_0200);
    chk("tgt_valid", {31'd0, f_valid_o}, 32'd1);
    chk("tgt_addr",  im_addr_o, 32'h0000_0208);

    // Redirect together with stall: redirect wins
    nxt();
    chk("tgt2_pc", f_pc_o, 32'h0000_0204);
    f_stall_i = 1'b1; x_bra_i = 1'b1; x_bra_target_i = 32'hFFFF_FFFC; #1;
    chk("bs_addr", im_addr_o, 32'hFFFF_FFFC);
    chk("bs_rd",   {31'd0, im_rd_o}, 32'd1);

    nxt(); f_stall_i = 1'b0; x_bra_i = 1'b0; #1;
    chk("bs_valid", {31'd0, f_valid_o}, 32'd0);
    chk("wrap_addr", im_addr_o, 32'h0000_0000);

    nxt(); #1;
    chk("top_pc",    f_pc_o, 32'hFFFF_FFFC);
    chk("top_ir",    f_ir_o, 32'h5A5A_FFFC);
    chk("top_valid", {31'd0, f_valid_o}, 32'd1);
    chk("top_addr",  im_addr_o, 32'h0000_0004);

    nxt(); #1;
    chk("wrap_pc",    f_pc_o, 32'h0000_0000);
    chk("wrap_ir",    f_ir_o, 32'hA5A5_0000);
    chk("wrap_valid", {31'd0, f_valid_o}, 32'd1);

    // Asynchronous reset mid-stream
    #2 rst_n_i = 1'b0; #1;
    chk("arst_valid", {31'd0, f_valid_o}, 32'd0);
    chk("arst_ir",    f_ir_o, 32'd0);

    nxt(); rst_n_i = 1'b1; #1;
    chk("reboot_rd",   {31'd0, im_rd_o}, 32'd1);
    chk("reboot_addr", im_addr_o, 32'h0000_0100);

    nxt(); #1;
    chk("reboot_valid0", {31'd0, f_valid_o}, 32'd0);
    chk("reboot_addr1",  im_addr_o, 32'h0000_0104);

    nxt(); #1;
    chk("reboot_pc",    f_pc_o, 32'h0000_0100);
    chk("reboot_valid", {31'd0, f_valid_o}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
